// File: rtl/data_memory_ctrl_if.sv
// Request/response bus between the load/store stage and the data memory controller.
interface data_memory_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        req_wren;
  logic [31:0] req_wdata;
  logic [2:0]  req_funct3;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_error;

  modport master (
    output req_valid, req_addr, req_wren, req_wdata, req_funct3, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_error
  );

  modport slave (
    input  req_valid, req_addr, req_wren, req_wdata, req_funct3, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_error
  );
endinterface

// File: rtl/data_memory_ctrl.sv
// Byte-addressable data memory with MMIO in/out ports and a valid/ready handshake.
module data_memory_ctrl #(
  parameter int unsigned WIDTH        = 32,
  parameter int unsigned DEPTH        = 1024,
  parameter logic [31:0] OUTPORT_ADDR = 32'h0000_FFFC,
  parameter logic [31:0] INPORT_ADDR  = 32'h0000_FFF8
) (
  input  logic             clk,
  input  logic             rst,
  data_memory_ctrl_if.slave bus,
  input  logic [WIDTH-1:0] inport,
  output logic [WIDTH-1:0] outport
);
  localparam int unsigned AW       = $clog2(DEPTH);
  localparam logic [32:0] RamLimit = 33'(DEPTH) << 2;

  typedef enum logic [1:0] {StIdle, StRead, StResp} state_e;

  state_e state_q, state_d;

  logic [WIDTH-1:0] mem_q [DEPTH];

  logic [1:0]       lane_q;
  logic [AW-1:0]    widx_q;
  logic [2:0]       f3_q;
  logic             sel_out_q, sel_in_q;
  logic [WIDTH-1:0] rsp_rdata_q;
  logic             rsp_error_q;
  logic [WIDTH-1:0] outport_q;
  logic [WIDTH-1:0] in_sync1_q, in_sync2_q;

  logic             is_ram, is_out, is_in, misaligned, illegal, acc_err, accept, ram_we;
  logic [3:0]       be;
  logic [WIDTH-1:0] wdata_rep, src, load_data;
  logic [7:0]       byte_sel;
  logic [15:0]      half_sel;
  logic             req_ready, rsp_valid;

  assign accept = (state_q == StIdle) && bus.req_valid;
  assign ram_we = accept && bus.req_wren && !acc_err && is_ram;

  // Decode the incoming request and classify faults
  always_comb begin
    is_ram     = {1'b0, bus.req_addr} < RamLimit;
    is_out     = bus.req_addr == OUTPORT_ADDR;
    is_in      = bus.req_addr == INPORT_ADDR;
    misaligned = ((bus.req_funct3[1:0] == 2'b01) && bus.req_addr[0]) ||
                 ((bus.req_funct3 == 3'b010) && (bus.req_addr[1:0] != 2'b00));
    illegal    = (bus.req_funct3 == 3'b011) || (bus.req_funct3[2:1] == 2'b11) ||
                 (bus.req_wren && bus.req_funct3[2]);
    acc_err    = misaligned || illegal || !(is_ram || is_out || is_in) ||
                 ((is_out || is_in) && (bus.req_funct3 != 3'b010)) ||
                 (bus.req_wren && is_in);
  end

  // Byte enables and lane-replicated store data
  always_comb begin
    be        = 4'b1111;
    wdata_rep = bus.req_wdata;
    case (bus.req_funct3[1:0])
      2'b00: begin
        be        = 4'b0001 << bus.req_addr[1:0];
        wdata_rep = {4{bus.req_wdata[7:0]}};
      end
      2'b01: begin
        be        = bus.req_addr[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{bus.req_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  // RAM write port, no reset on contents
  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem_q[bus.req_addr[AW+1:2]][8*b +: 8] <= wdata_rep[8*b +: 8];
      end
    end
  end

  // Select the load source and extend by the captured funct3
  always_comb begin
    src = mem_q[widx_q];
    if (sel_out_q)     src = outport_q;
    else if (sel_in_q) src = in_sync2_q;
    unique case (lane_q)
      2'd0:    byte_sel = src[7:0];
      2'd1:    byte_sel = src[15:8];
      2'd2:    byte_sel = src[23:16];
      default: byte_sel = src[31:24];
    endcase
    half_sel = lane_q[1] ? src[31:16] : src[15:0];
    case (f3_q)
      3'b000:  load_data = {{24{byte_sel[7]}}, byte_sel};
      3'b100:  load_data = {24'h0, byte_sel};
      3'b001:  load_data = {{16{half_sel[15]}}, half_sel};
      3'b101:  load_data = {16'h0, half_sel};
      default: load_data = src;
    endcase
  end

  // Datapath registers: capture on accept, register load data leaving READ
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lane_q      <= '0;
      widx_q      <= '0;
      f3_q        <= '0;
      sel_out_q   <= 1'b0;
      sel_in_q    <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_error_q <= 1'b0;
      outport_q   <= '0;
      in_sync1_q  <= '0;
      in_sync2_q  <= '0;
    end else begin
      in_sync1_q <= inport;
      in_sync2_q <= in_sync1_q;
      if (accept) begin
        lane_q      <= bus.req_addr[1:0];
        widx_q      <= bus.req_addr[AW+1:2];
        f3_q        <= bus.req_funct3;
        sel_out_q   <= is_out;
        sel_in_q    <= is_in;
        rsp_error_q <= acc_err;
        rsp_rdata_q <= '0;
        if (bus.req_wren && is_out && !acc_err) outport_q <= bus.req_wdata;
      end
      if (state_q == StRead) rsp_rdata_q <= load_data;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= StIdle;
    else      state_q <= state_d;
  end

  // FSM next state: faults and stores skip the read cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: if (bus.req_valid) state_d = (acc_err || bus.req_wren) ? StResp : StRead;
      StRead: state_d = StResp;
      StResp: if (bus.rsp_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs
  always_comb begin
    req_ready = (state_q == StIdle);
    rsp_valid = (state_q == StResp);
  end

  assign bus.req_ready = req_ready;
  assign bus.rsp_valid = rsp_valid;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_error = rsp_error_q;
  assign outport       = outport_q;
endmodule

// File: tb/tb_data_memory_ctrl.sv
// Scoreboard bench for data_memory_ctrl with a byte-level reference memory.
module tb_data_memory_ctrl;
  localparam int unsigned DEPTH = 1024;
  localparam logic [31:0] OUT_A = 32'h0000_FFFC;
  localparam logic [31:0] IN_A  = 32'h0000_FFF8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] inport, outport;

  data_memory_ctrl_if bus();

  data_memory_ctrl #(
    .WIDTH(32), .DEPTH(DEPTH), .OUTPORT_ADDR(OUT_A), .INPORT_ADDR(IN_A)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus), .inport(inport), .outport(outport)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int unsigned acc;
    int unsigned lat;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [7:0]  mem_m [DEPTH*4];
  logic [31:0] out_m = 0;
  logic [31:0] in_m  = 0;
  logic        rr_auto = 1'b0;
  bit          in_rsp = 1'b0;
  logic [31:0] hold_rdata;
  logic        hold_err;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: byte-addressed little-endian memory, faults from the access rules
  function automatic exp_t model(logic wren, logic [31:0] addr, logic [2:0] f3,
                                 logic [31:0] wdata);
    exp_t        e;
    int unsigned size;
    logic        ram, mo, mi, bad;
    logic [31:0] v;
    size = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    ram  = addr < DEPTH * 4;
    mo   = addr == OUT_A;
    mi   = addr == IN_A;
    bad  = 1'b0;
    if (f3 == 3 || f3 == 6 || f3 == 7) bad = 1'b1;
    if (wren && f3 >= 4) bad = 1'b1;
    if (addr % size != 0) bad = 1'b1;
    if (!ram && !mo && !mi) bad = 1'b1;
    if ((mo || mi) && f3 != 3'b010) bad = 1'b1;
    if (wren && mi) bad = 1'b1;
    e.err   = bad;
    e.rdata = 0;
    e.acc   = 0;
    e.lat   = (bad || wren) ? 1 : 2;
    if (!bad) begin
      if (wren) begin
        if (mo) out_m = wdata;
        else for (int i = 0; i < int'(size); i++) mem_m[addr + i] = wdata[8*i +: 8];
      end else begin
        v = 0;
        if (mo)      v = out_m;
        else if (mi) v = in_m;
        else for (int i = 0; i < int'(size); i++) v[8*i +: 8] = mem_m[addr + i];
        if (size == 1 && !f3[2]) v = {{24{v[7]}}, v[7:0]};
        if (size == 2 && !f3[2]) v = {{16{v[15]}}, v[15:0]};
        e.rdata = v;
      end
    end
    return e;
  endfunction

  task automatic issue(logic wren, logic [31:0] addr, logic [2:0] f3, logic [31:0] wdata);
    exp_t e;
    int   n;
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_wren   = wren;
    bus.req_addr   = addr;
    bus.req_funct3 = f3;
    bus.req_wdata  = wdata;
    n = 0;
    while (!bus.req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.req_ready) begin
      chk("req_ready_timeout", {31'h0, bus.req_ready}, 32'h1);
      bus.req_valid = 1'b0;
      return;
    end
    e     = model(wren, addr, f3, wdata);
    e.acc = cyc;
    sb.push_back(e);
    @(posedge clk);
    #1;
    // Scramble request fields after accept; the controller must ignore them
    bus.req_valid  = 1'b0;
    bus.req_addr   = $urandom;
    bus.req_wdata  = $urandom;
    bus.req_funct3 = 3'($urandom);
    bus.req_wren   = 1'($urandom);
  endtask

  function automatic logic [31:0] rand_addr();
    int unsigned r;
    r = $urandom_range(0, 9);
    if (r <= 5) return 32'($urandom_range(0, 63));
    if (r == 6) return OUT_A;
    if (r == 7) return IN_A;
    if (r == 8) return 32'(DEPTH * 4 - 4 + $urandom_range(0, 3));
    return 32'(DEPTH * 4 + $urandom_range(0, 255));
  endfunction

  // Randomised consumer backpressure
  always @(posedge clk) begin
    if (rr_auto) begin
      #1;
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: latency on first presentation, stability while held, compare on handshake
  initial begin
    forever begin
      @(negedge clk);
      if (rst && bus.rsp_valid) begin
        if (!in_rsp) begin
          if (sb.size() == 0) begin
            chk("unexpected_rsp", {31'h0, bus.rsp_valid}, 32'h0);
          end else begin
            chk("latency", cyc - sb[0].acc, sb[0].lat);
          end
          in_rsp     = 1'b1;
          hold_rdata = bus.rsp_rdata;
          hold_err   = bus.rsp_error;
        end else begin
          chk("held_rdata", bus.rsp_rdata, hold_rdata);
          chk("held_error", {31'h0, bus.rsp_error}, {31'h0, hold_err});
        end
        chk("req_ready_in_resp", {31'h0, bus.req_ready}, 32'h0);
        if (bus.rsp_ready) begin
          if (sb.size() != 0) begin
            chk("rsp_rdata", bus.rsp_rdata, sb[0].rdata);
            chk("rsp_error", {31'h0, bus.rsp_error}, {31'h0, sb[0].err});
            void'(sb.pop_front());
          end
          in_rsp = 1'b0;
        end
      end
    end
  end

  initial begin
    int n;
    bus.req_valid  = 1'b0;
    bus.req_addr   = 0;
    bus.req_wren   = 1'b0;
    bus.req_wdata  = 0;
    bus.req_funct3 = 3'b010;
    bus.rsp_ready  = 1'b1;
    inport         = 32'h55;
    in_m           = 32'h55;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", {31'h0, bus.req_ready}, 32'h1);
    chk("rst_rsp_valid", {31'h0, bus.rsp_valid}, 32'h0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
    chk("rst_rsp_error", {31'h0, bus.rsp_error}, 32'h0);
    chk("rst_outport", outport, 32'h0);
    rst = 1'b1;

    // Known contents for every RAM word the stimulus can load from
    for (int a = 0; a < 64; a += 4) issue(1'b1, 32'(a), 3'b010, 32'h0);
    issue(1'b1, 32'(DEPTH * 4 - 4), 3'b010, 32'hA5C3_0F96);

    // Load extension
    issue(1'b1, 32'h10, 3'b010, 32'h8899_AABB);
    issue(1'b0, 32'h11, 3'b000, 0);
    issue(1'b0, 32'h11, 3'b100, 0);
    issue(1'b0, 32'h12, 3'b001, 0);
    issue(1'b0, 32'h12, 3'b101, 0);
    issue(1'b0, 32'h10, 3'b010, 0);

    // Byte enables
    issue(1'b1, 32'h20, 3'b010, 32'h0);
    issue(1'b1, 32'h23, 3'b000, 32'hFFFF_FF7F);
    issue(1'b1, 32'h20, 3'b001, 32'hABCD_1234);
    issue(1'b0, 32'h20, 3'b010, 0);

    // Faults, then confirm neighbouring contents untouched
    issue(1'b0, 32'h02, 3'b010, 0);
    issue(1'b0, 32'h01, 3'b001, 0);
    issue(1'b0, 32'h10, 3'b011, 0);
    issue(1'b1, 32'(DEPTH * 4), 3'b010, 32'h1111_1111);
    issue(1'b1, 32'h02, 3'b010, 32'h2222_2222);
    issue(1'b1, 32'h10, 3'b100, 32'h3333_3333);
    issue(1'b0, 32'h00, 3'b010, 0);
    issue(1'b0, 32'h10, 3'b010, 0);
    issue(1'b0, 32'(DEPTH * 4 - 4), 3'b010, 0);

    // MMIO
    issue(1'b1, OUT_A, 3'b010, 32'hDEAD_BEEF);
    chk("outport_after_sw", outport, 32'hDEAD_BEEF);
    issue(1'b1, OUT_A, 3'b000, 32'h0000_0011);
    chk("outport_after_sb_err", outport, 32'hDEAD_BEEF);
    issue(1'b0, IN_A, 3'b010, 0);
    issue(1'b0, OUT_A, 3'b010, 0);
    issue(1'b1, IN_A, 3'b010, 32'h1234_5678);

    // Backpressure: hold the response for five cycles
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b0;
    issue(1'b0, 32'h10, 3'b010, 0);
    @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("stall_rsp_valid", {31'h0, bus.rsp_valid}, 32'h1);
      chk("stall_req_ready", {31'h0, bus.req_ready}, 32'h0);
    end
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("after_stall_req_ready", {31'h0, bus.req_ready}, 32'h1);
    chk("after_stall_rsp_valid", {31'h0, bus.rsp_valid}, 32'h0);

    // Randomised traffic with backpressure
    rr_auto = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if (i == 150) begin
        inport = $urandom;
        in_m   = inport;
        repeat (3) @(negedge clk);
      end
      issue(1'($urandom), rand_addr(), 3'($urandom), $urandom);
    end
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain_random", sb.size(), 0);
    rr_auto = 1'b0;
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b1;

    // Reset while a load sits in READ
    issue(1'b1, OUT_A, 3'b010, 32'hCAFE_F00D);
    issue(1'b0, 32'h10, 3'b010, 0);
    #2;
    rst = 1'b0;
    #1;
    chk("midrst_rsp_valid", {31'h0, bus.rsp_valid}, 32'h0);
    chk("midrst_rsp_rdata", bus.rsp_rdata, 32'h0);
    chk("midrst_rsp_error", {31'h0, bus.rsp_error}, 32'h0);
    chk("midrst_outport", outport, 32'h0);
    chk("midrst_req_ready", {31'h0, bus.req_ready}, 32'h1);
    sb.delete();
    in_rsp = 1'b0;
    out_m  = 0;
    @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    issue(1'b0, 32'h10, 3'b010, 0);
    issue(1'b0, OUT_A, 3'b010, 0);
    issue(1'b0, IN_A, 3'b010, 0);
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain_final", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/data_memory_ctrl.md
Name: data_memory_ctrl

Overview:
- Byte-addressable data memory controller for the RISC-V core's load/store stage.
- Holds a parametrised-depth word RAM with per-byte write enables and load sign/zero extension by funct3.
- Flags misaligned, illegal and out-of-range accesses.
- Provides memory-mapped output and input ports.
- Uses a valid/ready request/response handshake, so the core can stall on memory.

Parameters:
WIDTH, 32, data/address width; fixed at 32 (4 byte lanes)
DEPTH, 1024, RAM depth in 32-bit words; power of two
OUTPORT_ADDR, 32'h0000_FFFC, byte address of output port register
INPORT_ADDR, 32'h0000_FFF8, byte address of input port

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
req_valid  in  1  request present
req_ready  out  1  controller accepts a request this cycle
req_addr  in  32  byte address
req_wren  in  1  0 = load, 1 = store
req_wdata  in  32  store data (right-aligned: byte in [7:0], half in [15:0])
req_funct3  in  funct3_t (3)  LOAD_STORE_FNS encoding: 000 B, 001 H, 010 W, 100 BU, 101 HU
rsp_valid  out  1  response available
rsp_ready  in  1  consumer takes response
rsp_rdata  out  32  load result, extended; 0 for stores and errors
rsp_error  out  1  access faulted
inport  in  32  asynchronous external input
outport  out  32  output port register

Behaviour:
- Reset (rst=0, async): state=IDLE, rsp_valid=0, rsp_rdata=0, rsp_error=0, outport=0, inport sync flops=0. RAM contents are not reset.
- Reset mid-operation aborts any in-flight access. No response is produced for it.
- FSM states:
  - IDLE: req_ready=1; accept on req_valid&&req_ready.
  - READ: one cycle; RAM read data arrives.
  - RESP: rsp_valid=1; held with rsp_rdata/rsp_error stable until rsp_ready=1, then IDLE.
  - req_ready=0 outside IDLE. A new request is never accepted in the same cycle a response retires.
- Address decode on accept; AW=$clog2(DEPTH); word index = req_addr[AW+1:2]; lane = req_addr[1:0].
  - RAM hit: req_addr < DEPTH*4.
  - MMIO hit: req_addr == OUTPORT_ADDR or INPORT_ADDR.
  - Anything else: range error.
- Error conditions, checked at accept:
  - misaligned: H/HU with addr[0]=1; W with addr[1:0]!=0
  - illegal funct3: 011, 110, 111 for any access; 100/101 for stores
  - range error
  - MMIO access other than funct3=010
  - store to INPORT_ADDR
- On error: no RAM or outport write; IDLE→RESP next cycle with rsp_error=1, rsp_rdata=0.
- Store, RAM:
  - Written at the accept clock edge with byte enables.
  - SB: lane = addr[1:0], data = wdata[7:0] replicated.
  - SH: lanes {addr[1],0} and {addr[1],1}, data = wdata[15:0] replicated.
  - SW: all lanes.
  - IDLE→RESP; rsp_rdata=0, rsp_error=0.
- Store to OUTPORT_ADDR: outport <= req_wdata at the accept edge; IDLE→RESP.
- Load, RAM: IDLE→READ→RESP. At READ→RESP, rsp_rdata is registered from RAM q using the captured lane and funct3:
  - LB/LBU: byte at lane, sign- or zero-extended.
  - LH/LHU: half at addr[1], sign- or zero-extended.
  - LW: word.
- Load, MMIO: OUTPORT_ADDR returns current outport; INPORT_ADDR returns the 2-flop synchronised inport. Same IDLE→READ→RESP timing as RAM loads.
- Latency, accept edge to rsp_valid: store/error 1 cycle; load 2 cycles. Minimum spacing between accepts: 2 cycles for stores, 3 for loads.
- Captured address, funct3 and lane are held in registers. Request inputs may change after acceptance without effect.
- RAM reads are synchronous, 1-cycle. The read address is driven from captured registers in READ.

Test Plan:
- SW 0x8899AABB @0x10, then LB @0x11, LBU @0x11, LH @0x12, LHU @0x12, LW @0x10 -> 0xFFFFFFAA, 0x000000AA, 0xFFFF8899, 0x00008899, 0x8899AABB; load rsp_valid exactly 2 cycles after accept.
- SW 0 @0x20, SB 0x7F @0x23, SH 0x1234 @0x20 -> LW @0x20 returns 0x7F001234.
- LW @0x02, LH @0x01, funct3=011, SW @DEPTH*4 -> rsp_error=1, rsp_rdata=0 each; prior contents at those words unchanged.
- SW 0xDEADBEEF @OUTPORT_ADDR -> outport=0xDEADBEEF the cycle after accept; SB @OUTPORT_ADDR -> error, outport unchanged; inport=0x55, LW @INPORT_ADDR -> 0x00000055.
- LW with rsp_ready=0 for 5 cycles -> rsp_valid, rsp_rdata stable, req_ready=0 throughout; rsp_ready=1 -> IDLE next cycle, req_ready=1.
- rst asserted while in READ -> outputs immediately at reset values; after release, first request behaves normally; outport=0.
